// File: rtl/agc_ctr_pkg.sv
// Shared types and defaults for the counter-cell scheduler slice.
package agc_ctr_pkg;

    typedef enum logic [1:0] {IDLE, STALL, READ, WRITE} ctr_state_t;
    typedef enum logic {PINC, MINC} ctr_dir_t;

    localparam logic [10:0] CTR_BASE_DEFAULT = 11'o024;

endpackage

// File: rtl/ones_comp_incdec.sv
// Ones-complement +1/-1 of a counter word, flagging overflow/underflow.
module ones_comp_incdec
    import agc_ctr_pkg::*;
#(
    parameter int unsigned DATA_W = 15
) (
    input  logic [DATA_W-1:0] value,
    input  ctr_dir_t          dir,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] POS_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MAX  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] NEG_ZERO = '1;

    always_comb begin
        result = value;
        ovf    = 1'b0;
        if (dir == PINC) begin
            if (value == POS_MAX) begin
                result = '0;
                ovf    = 1'b1;
            end else if (value == NEG_ZERO) begin
                result = POS_ONE;
            end else begin
                result = value + POS_ONE;
            end
        end else begin
            if (value == NEG_MAX) begin
                result = NEG_ZERO;
                ovf    = 1'b1;
            end else if (value == '0) begin
                result = NEG_ZERO - POS_ONE;
            end else begin
                result = value - POS_ONE;
            end
        end
    end

endmodule

// File: rtl/counter_cell_scheduler.sv
// Steals RAM cycles from the Core to apply pending PINC/MINC requests to
// counter cells with a stall / read / write sequence.
module counter_cell_scheduler
    import agc_ctr_pkg::*;
#(
    parameter int unsigned          N_CTR    = 8,
    parameter int unsigned          ADDR_W   = 11,
    parameter int unsigned          DATA_W   = 15,
    parameter logic [ADDR_W-1:0]    CTR_BASE = ADDR_W'(CTR_BASE_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CTR-1:0]  pinc_req,
    input  logic [N_CTR-1:0]  minc_req,
    input  logic              core_quiet,
    output logic              steal_stall,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_sel,
    output logic [N_CTR-1:0]  ovf_pulse,
    output logic              drop_err
);

    localparam int unsigned IDX_W = (N_CTR > 1) ? $clog2(N_CTR) : 1;

    ctr_state_t        state_q;
    ctr_dir_t          dir_q;
    ctr_dir_t          sel_dir;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic [N_CTR-1:0]  pend_p_q;
    logic [N_CTR-1:0]  pend_m_q;
    logic [N_CTR-1:0]  pend_p_d;
    logic [N_CTR-1:0]  pend_m_d;
    logic              drop_any;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inc_result;
    logic              inc_ovf;

    // The serviced bit clears first so a request landing in WRITE re-arms it.
    // An opposite request for the counter in service cannot cancel the bit that
    // is already being written, so it is queued instead.
    always_comb begin
        pend_p_d = pend_p_q;
        pend_m_d = pend_m_q;
        drop_any = 1'b0;
        if (state_q == WRITE) begin
            if (dir_q == PINC) pend_p_d[idx_q] = 1'b0;
            else               pend_m_d[idx_q] = 1'b0;
        end
        for (int unsigned i = 0; i < N_CTR; i++) begin
            if (pinc_req[i] && !minc_req[i]) begin
                if (pend_p_d[i])
                    drop_any = 1'b1;
                else if (pend_m_d[i] && !((state_q != IDLE) && (IDX_W'(i) == idx_q) && (dir_q == MINC)))
                    pend_m_d[i] = 1'b0;
                else
                    pend_p_d[i] = 1'b1;
            end else if (minc_req[i] && !pinc_req[i]) begin
                if (pend_m_d[i])
                    drop_any = 1'b1;
                else if (pend_p_d[i] && !((state_q != IDLE) && (IDX_W'(i) == idx_q) && (dir_q == PINC)))
                    pend_p_d[i] = 1'b0;
                else
                    pend_m_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_dir   = PINC;
        for (int unsigned i = 0; i < N_CTR; i++) begin
            if (!sel_valid && (pend_p_d[i] ^ pend_m_d[i])) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_dir   = pend_p_d[i] ? PINC : MINC;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= PINC;
            idx_q       <= '0;
            pend_p_q    <= '0;
            pend_m_q    <= '0;
            addr_q      <= '0;
            steal_stall <= 1'b0;
            ram_sel     <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            pend_p_q <= pend_p_d;
            pend_m_q <= pend_m_d;
            drop_err <= drop_any;
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q     <= STALL;
                        idx_q       <= sel_idx;
                        dir_q       <= sel_dir;
                        addr_q      <= CTR_BASE + ADDR_W'(sel_idx);
                        steal_stall <= 1'b1;
                        ram_sel     <= 1'b1;
                    end
                end
                STALL: begin
                    if (core_quiet) state_q <= READ;
                end
                READ: begin
                    state_q <= WRITE;
                end
                WRITE: begin
                    state_q     <= IDLE;
                    addr_q      <= '0;
                    steal_stall <= 1'b0;
                    ram_sel     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ones_comp_incdec #(
        .DATA_W (DATA_W)
    ) u_incdec (
        .value  (ram_rd_data),
        .dir    (dir_q),
        .result (inc_result),
        .ovf    (inc_ovf)
    );

    // Read data arrives during WRITE, so the write path stays combinational.
    assign ram_rd_addr = addr_q;
    assign ram_wr_addr = addr_q;
    assign ram_wr_en   = (state_q == WRITE);
    assign ram_wr_data = ram_wr_en ? inc_result : '0;
    assign ovf_pulse   = (ram_wr_en && inc_ovf) ? (N_CTR'(1) << idx_q) : '0;

endmodule

// File: tb/tb_counter_cell_scheduler.sv
// Bench for counter_cell_scheduler: RAM environment, abstract model and
// directed scenarios with hand-computed expectations.
module tb_counter_cell_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pinc_req = '0;
    logic [7:0]  minc_req = '0;
    logic        core_quiet = 1'b1;
    logic        steal_stall;
    logic [10:0] ram_rd_addr;
    logic [14:0] ram_rd_data;
    logic [10:0] ram_wr_addr;
    logic [14:0] ram_wr_data;
    logic        ram_wr_en;
    logic        ram_sel;
    logic [7:0]  ovf_pulse;
    logic        drop_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    logic [14:0] ram [0:2047];
    logic        ld_en = 1'b0;
    int          ld_idx = 0;
    logic [14:0] ld_val = '0;

    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int drop_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] ovf_last = '0;

    always #5 clock = ~clock;

    counter_cell_scheduler #(
        .N_CTR    (8),
        .ADDR_W   (11),
        .DATA_W   (15),
        .CTR_BASE (11'o024)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pinc_req    (pinc_req),
        .minc_req    (minc_req),
        .core_quiet  (core_quiet),
        .steal_stall (steal_stall),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_en   (ram_wr_en),
        .ram_sel     (ram_sel),
        .ovf_pulse   (ovf_pulse),
        .drop_err    (drop_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0o required=%0o at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Ones-complement arithmetic done on signed integers.
    function automatic int oc_int(input logic [14:0] v);
        logic [14:0] t;
        t = ~v;
        return v[14] ? -int'(t) : int'(v);
    endfunction

    function automatic bit oc_ovf(input logic [14:0] v, input bit dec);
        int n;
        n = oc_int(v);
        return dec ? (n - 1 < -16383) : (n + 1 > 16383);
    endfunction

    function automatic logic [14:0] oc_val(input logic [14:0] v, input bit dec);
        int n;
        n = oc_int(v) + (dec ? -1 : 1);
        if (!dec && n > 16383) return 15'o00000;
        if (dec && n < -16383) return 15'o77777;
        if (n == 0 && !dec && v[14]) return 15'o77777;
        if (n >= 0) return 15'(n);
        return ~15'(-n);
    endfunction

    // RAM environment: synchronous read, one-cycle latency.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        ram_rd_data <= ram[ram_rd_addr];
        if (ld_en) ram[11'o024 + ld_idx] <= ld_val;
        else if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    end

    // Model: pending request sets and service phase (0 idle, 1 stall, 2 read, 3 write).
    logic [7:0]  mp, mm;
    int          m_phase;
    int          m_idx;
    bit          m_dir;
    bit          m_drop;
    logic [14:0] m_ctr [0:7];

    always @(posedge clock or posedge reset) begin : mdl
        logic [7:0] np, nm;
        bit dr;
        int sel;
        if (reset) begin
            mp <= '0; mm <= '0; m_phase <= 0; m_idx <= 0; m_dir <= 1'b0; m_drop <= 1'b0;
        end else begin
            np = mp; nm = mm; dr = 1'b0;
            if (m_phase == 3) begin
                if (m_dir) nm[m_idx] = 1'b0; else np[m_idx] = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                bit busy;
                busy = (m_phase != 0) && (i == m_idx);
                if (pinc_req[i] && !minc_req[i]) begin
                    if (np[i]) dr = 1'b1;
                    else if (nm[i] && !(busy && m_dir)) nm[i] = 1'b0;
                    else np[i] = 1'b1;
                end else if (minc_req[i] && !pinc_req[i]) begin
                    if (nm[i]) dr = 1'b1;
                    else if (np[i] && !(busy && !m_dir)) np[i] = 1'b0;
                    else nm[i] = 1'b1;
                end
            end
            mp <= np; mm <= nm; m_drop <= dr;
            case (m_phase)
                0: begin
                    sel = -1;
                    for (int i = 7; i >= 0; i--) if (np[i] ^ nm[i]) sel = i;
                    if (sel >= 0) begin
                        m_phase <= 1; m_idx <= sel; m_dir <= nm[sel];
                    end
                end
                1: if (core_quiet) m_phase <= 2;
                2: m_phase <= 3;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(posedge clock) begin
        if (ld_en) m_ctr[ld_idx] <= ld_val;
        else if (!reset && m_phase == 3) m_ctr[m_idx] <= oc_val(m_ctr[m_idx], m_dir);
    end

    // Compare process plus write/pulse logging.
    always @(negedge clock) begin
        if (!reset) begin
            logic [7:0] e_ovf;
            e_ovf = '0;
            if (m_phase == 3 && oc_ovf(m_ctr[m_idx], m_dir)) e_ovf[m_idx] = 1'b1;
            chk("steal_stall", steal_stall, m_phase != 0);
            chk("ram_sel", ram_sel, m_phase != 0);
            chk("ram_wr_en", ram_wr_en, m_phase == 3);
            chk("drop_err", drop_err, m_drop);
            chk("ovf_pulse", ovf_pulse, e_ovf);
            if (m_phase == 2) chk("ram_rd_addr", ram_rd_addr, 11'o024 + m_idx);
            if (m_phase == 3) begin
                chk("ram_wr_addr", ram_wr_addr, 11'o024 + m_idx);
                chk("ram_wr_data", ram_wr_data, oc_val(m_ctr[m_idx], m_dir));
            end
            if (ram_wr_en) begin
                wq_addr.push_back(int'(ram_wr_addr));
                wq_data.push_back(int'(ram_wr_data));
                wq_cyc.push_back(cyc);
            end
            if (drop_err) drop_cnt++;
            if (|ovf_pulse) begin
                ovf_cnt++;
                ovf_last = ovf_pulse;
            end
        end
    end

    task automatic load(input int i, input logic [14:0] v);
        @(posedge clock); #1;
        ld_en = 1'b1; ld_idx = i; ld_val = v;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] m);
        @(posedge clock); #1;
        pinc_req = p; minc_req = m; t0 = cyc;
        @(posedge clock); #1;
        pinc_req = '0; minc_req = '0;
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        drop_cnt = 0; ovf_cnt = 0; ovf_last = '0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((m_phase != 0 || mp != 0 || mm != 0) && k < 60) begin
            @(posedge clock);
            k++;
        end
        chk(name, k < 60, 1'b1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_steal_stall", steal_stall, 1'b0);
        chk("rst_ram_sel", ram_sel, 1'b0);
        chk("rst_wr_en", ram_wr_en, 1'b0);
        chk("rst_drop_err", drop_err, 1'b0);
        chk("rst_ovf_pulse", ovf_pulse, 8'h00);
        @(posedge clock); #1;
        reset = 1'b0;

        // single increment, 3-cycle latency
        load(2, 15'o00005);
        clear_log();
        drive(8'h04, 8'h00);
        @(negedge clock);
        chk("t2_stall_next", steal_stall, 1'b1);
        wait_idle("t2_timeout");
        chk("t2_nwrites", wq_addr.size(), 1);
        chk("t2_addr", wq_addr[0], 11'o026);
        chk("t2_data", wq_data[0], 15'o00006);
        chk("t2_latency", wq_cyc[0] - t0, 3);
        chk("t2_no_ovf", ovf_cnt, 0);

        // boundaries
        load(0, 15'o37777);
        clear_log();
        drive(8'h01, 8'h00);
        wait_idle("t3a_timeout");
        chk("t3a_data", wq_data[0], 15'o00000);
        chk("t3a_ovf_cnt", ovf_cnt, 1);
        chk("t3a_ovf_bit", ovf_last, 8'h01);

        load(1, 15'o00000);
        clear_log();
        drive(8'h00, 8'h02);
        wait_idle("t3b_timeout");
        chk("t3b_addr", wq_addr[0], 11'o025);
        chk("t3b_data", wq_data[0], 15'o77776);
        chk("t3b_no_ovf", ovf_cnt, 0);

        load(3, 15'o77777);
        clear_log();
        drive(8'h08, 8'h00);
        wait_idle("t3c_timeout");
        chk("t3c_negzero_inc", wq_data[0], 15'o00001);

        load(4, 15'o40000);
        clear_log();
        drive(8'h00, 8'h10);
        wait_idle("t3d_timeout");
        chk("t3d_underflow", wq_data[0], 15'o77777);
        chk("t3d_ovf_bit", ovf_last, 8'h10);

        // two counters at once: lowest index first, IDLE gap between steals
        load(3, 15'o00012);
        load(5, 15'o00024);
        clear_log();
        drive(8'h28, 8'h00);
        wait_idle("t4_timeout");
        chk("t4_nwrites", wq_addr.size(), 2);
        chk("t4_first_addr", wq_addr[0], 11'o027);
        chk("t4_first_data", wq_data[0], 15'o00013);
        chk("t4_second_addr", wq_addr[1], 11'o031);
        chk("t4_second_data", wq_data[1], 15'o00025);
        chk("t4_gap", wq_cyc[1] - wq_cyc[0], 4);

        // Core busy: hold STALL, cancel and drop while waiting
        load(0, 15'o00144);
        load(4, 15'o00062);
        load(6, 15'o00007);
        clear_log();
        core_quiet = 1'b0;
        drive(8'h01, 8'h00);
        drive(8'h10, 8'h00);
        drive(8'h00, 8'h10);
        drive(8'h40, 8'h00);
        drive(8'h40, 8'h00);
        drive(8'h10, 8'h10);
        @(negedge clock);
        chk("t6_held_stall", steal_stall, 1'b1);
        chk("t6_no_write", wq_addr.size(), 0);
        chk("t5_drop_cnt", drop_cnt, 1);
        @(posedge clock); #1;
        core_quiet = 1'b1;
        wait_idle("t6_timeout");
        chk("t6_nwrites", wq_addr.size(), 2);
        chk("t6_first_addr", wq_addr[0], 11'o024);
        chk("t6_first_data", wq_data[0], 15'o00145);
        chk("t5_second_addr", wq_addr[1], 11'o032);
        chk("t5_second_data", wq_data[1], 15'o00010);
        chk("t5_ram4_kept", ram[11'o030], 15'o00062);

        // reset in the middle of READ
        load(7, 15'o00011);
        clear_log();
        drive(8'h80, 8'h00);
        @(posedge clock); #1;
        chk("t1_in_read_sel", ram_sel, 1'b1);
        reset = 1'b1;
        #1;
        chk("t1_stall_clr", steal_stall, 1'b0);
        chk("t1_wr_en_clr", ram_wr_en, 1'b0);
        chk("t1_sel_clr", ram_sel, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("t1_no_write", wq_addr.size(), 0);
        chk("t1_idle_after", steal_stall, 1'b0);
        chk("t1_ram7_kept", ram[11'o033], 15'o00011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog simulation did not complete, actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
